// File: rtl/rom_arbiter_if.sv
// Request/ack and ROM bus bundle for the ROM arbiter.
// slave: arbiter side; master: requester side; rom: ROM chip side.
interface rom_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  F_REQ;
    logic [ADDR_WIDTH-1:0] F_ADDR;
    logic                  F_ACK;
    logic [DATA_WIDTH-1:0] F_DATA;
    logic                  D_REQ;
    logic [ADDR_WIDTH-1:0] D_ADDR;
    logic                  D_ACK;
    logic [DATA_WIDTH-1:0] D_DATA;
    logic                  BUSY;
    logic [ADDR_WIDTH-1:0] ROM_A;
    logic                  ROM_CS_bar;
    logic                  ROM_OE_bar;
    logic                  ROM_WE_bar;
    logic [DATA_WIDTH-1:0] ROM_Q;

    modport slave (
        input  F_REQ, F_ADDR, D_REQ, D_ADDR, ROM_Q,
        output F_ACK, F_DATA, D_ACK, D_DATA, BUSY,
        output ROM_A, ROM_CS_bar, ROM_OE_bar, ROM_WE_bar
    );

    modport master (
        output F_REQ, F_ADDR, D_REQ, D_ADDR,
        input  F_ACK, F_DATA, D_ACK, D_DATA, BUSY
    );

    modport rom (
        input  ROM_A, ROM_CS_bar, ROM_OE_bar, ROM_WE_bar,
        output ROM_Q
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port (fetch/data) access sequencer for one asynchronous ROM.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin instead of fetch-first priority.
module rom_arbiter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 6
) (
    input logic       CLK,
    input logic       RST_bar,
    rom_arbiter_if.slave bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("rom_arbiter: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] rom_a, rom_a_n;
    logic                  rom_en, rom_en_n;
    logic                  grant_d, grant_d_n;
    logic                  pick_d;
    logic                  f_ack, f_ack_n;
    logic                  d_ack, d_ack_n;
    logic [DATA_WIDTH-1:0] f_data, f_data_n;
    logic [DATA_WIDTH-1:0] d_data, d_data_n;
    logic                  busy, busy_n;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic last_d, last_d_n;

    // On a tie, serve whichever port was not served last.
    always_comb begin
        pick_d = bus.D_REQ && (!bus.F_REQ || !last_d);
    end
`else
    // Fetch always wins a tie.
    always_comb begin
        pick_d = bus.D_REQ && !bus.F_REQ;
    end
`endif

    // Next-state and next-output logic; ROM_Q is only read while selected.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rom_a_n   = rom_a;
        rom_en_n  = rom_en;
        grant_d_n = grant_d;
        f_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        f_data_n  = f_data;
        d_data_n  = d_data;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        last_d_n  = last_d;
`endif
        unique case (state)
            IDLE: begin
                if (bus.F_REQ || bus.D_REQ) begin
                    grant_d_n = pick_d;
                    rom_a_n   = pick_d ? bus.D_ADDR : bus.F_ADDR;
                    cnt_n     = CNT_INIT;
                    rom_en_n  = 1'b1;
                    state_n   = ACCESS;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                    last_d_n  = pick_d;
`endif
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    rom_en_n = 1'b0;
                    state_n  = DONE;
                    if (grant_d) begin
                        d_data_n = bus.ROM_Q;
                        d_ack_n  = 1'b1;
                    end else begin
                        f_data_n = bus.ROM_Q;
                        f_ack_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                rom_en_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Register all state and outputs; synchronous reset aborts any access.
    always_ff @(posedge CLK) begin
        if (!RST_bar) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rom_a   <= '0;
            rom_en  <= 1'b0;
            grant_d <= 1'b0;
            f_ack   <= 1'b0;
            d_ack   <= 1'b0;
            f_data  <= '0;
            d_data  <= '0;
            busy    <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_d  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rom_a   <= rom_a_n;
            rom_en  <= rom_en_n;
            grant_d <= grant_d_n;
            f_ack   <= f_ack_n;
            d_ack   <= d_ack_n;
            f_data  <= f_data_n;
            d_data  <= d_data_n;
            busy    <= busy_n;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_d  <= last_d_n;
`endif
        end
    end

    assign bus.ROM_A      = rom_a;
    assign bus.ROM_CS_bar = !rom_en;
    assign bus.ROM_OE_bar = !rom_en;
    assign bus.ROM_WE_bar = 1'b1;
    assign bus.F_ACK      = f_ack;
    assign bus.D_ACK      = d_ack;
    assign bus.F_DATA     = f_data;
    assign bus.D_DATA     = d_data;
    assign bus.BUSY       = busy;

endmodule
